// File: rtl/hps_matrix_loader_if.sv
// HPS PIO word transfer bundle: four-phase req/ack with a 32-bit data word.
interface hps_matrix_loader_if;
  logic        hps_req;
  logic [31:0] hps_data;
  logic        hps_ack;

  modport master (output hps_req, output hps_data, input hps_ack);
  modport slave  (input hps_req, input hps_data, output hps_ack);
endinterface

// File: rtl/hps_matrix_loader.sv
// Loads two packed matrix operands from the HPS over a four-phase handshake,
// packing elements from the MSB of each 200-bit register.
module hps_matrix_loader #(
  parameter int unsigned ELEM_W    = 8,
  parameter int unsigned MAX_ELEMS = 25
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [1:0]                  mat_size,
  hps_matrix_loader_if.slave          hps,
  output logic [ELEM_W*MAX_ELEMS-1:0] matrix1_out,
  output logic [ELEM_W*MAX_ELEMS-1:0] matrix2_out,
  output logic                        busy,
  output logic                        done,
  output logic                        loaded
);

  localparam int unsigned MAT_W = ELEM_W * MAX_ELEMS;
  localparam int unsigned EPW   = 4;

  typedef enum logic [1:0] {IDLE, WAIT_REQ, WAIT_REL, DONE} state_e;

  state_e             state_q, state_d;
  logic [1:0]         size_q, size_d;
  logic [3:0]         word_cnt_q, word_cnt_d;
  logic [MAT_W-1:0]   mat1_q, mat1_d;
  logic [MAT_W-1:0]   mat2_q, mat2_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               loaded_q, loaded_d;

  logic [4:0]         elems_c;
  logic [2:0]         wpm_c;
  logic               in_m1_c;
  logic [2:0]         line_c;
  logic [4:0]         base_c;
  logic               last_c;

  // Geometry of the latched size and the slot window addressed by word_cnt.
  always_comb begin
    elems_c = 5'd4;
    wpm_c   = 3'd1;
    case (size_q)
      2'b00: begin elems_c = 5'd4;  wpm_c = 3'd1; end
      2'b01: begin elems_c = 5'd9;  wpm_c = 3'd3; end
      2'b10: begin elems_c = 5'd16; wpm_c = 3'd4; end
      default: begin elems_c = 5'd25; wpm_c = 3'd7; end
    endcase
    in_m1_c = word_cnt_q < {1'b0, wpm_c};
    line_c  = in_m1_c ? word_cnt_q[2:0] : 3'(word_cnt_q - {1'b0, wpm_c});
    base_c  = {line_c, 2'b00};
    last_c  = word_cnt_q == ({wpm_c, 1'b0} - 4'd1);
  end

  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    word_cnt_d = word_cnt_q;
    mat1_d     = mat1_q;
    mat2_d     = mat2_q;
    ack_d      = ack_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    loaded_d   = loaded_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          size_d     = mat_size;
          mat1_d     = '0;
          mat2_d     = '0;
          word_cnt_d = 4'd0;
          loaded_d   = 1'b0;
          busy_d     = 1'b1;
          state_d    = WAIT_REQ;
        end
      end
      WAIT_REQ: begin
        if (hps.hps_req) begin
          ack_d   = 1'b1;
          state_d = WAIT_REL;
          // Byte j lands in element base+j; bytes past the last element are dropped.
          for (int j = 0; j < int'(EPW); j++) begin
            for (int k = 0; k < int'(MAX_ELEMS); k++) begin
              if ((5'(k) == base_c + 5'(j)) && (5'(k) < elems_c)) begin
                if (in_m1_c)
                  mat1_d[(int'(MAX_ELEMS) - 1 - k) * int'(ELEM_W) +: ELEM_W] =
                    hps.hps_data[(3 - j) * int'(ELEM_W) +: ELEM_W];
                else
                  mat2_d[(int'(MAX_ELEMS) - 1 - k) * int'(ELEM_W) +: ELEM_W] =
                    hps.hps_data[(3 - j) * int'(ELEM_W) +: ELEM_W];
              end
            end
          end
        end
      end
      WAIT_REL: begin
        if (!hps.hps_req) begin
          ack_d      = 1'b0;
          word_cnt_d = word_cnt_q + 4'd1;
          state_d    = last_c ? DONE : WAIT_REQ;
        end
      end
      DONE: begin
        done_d   = 1'b1;
        loaded_d = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      size_q     <= 2'b00;
      word_cnt_q <= 4'd0;
      mat1_q     <= '0;
      mat2_q     <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      loaded_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      word_cnt_q <= word_cnt_d;
      mat1_q     <= mat1_d;
      mat2_q     <= mat2_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      loaded_q   <= loaded_d;
    end
  end

  assign hps.hps_ack = ack_q;
  assign matrix1_out = mat1_q;
  assign matrix2_out = mat2_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign loaded      = loaded_q;

endmodule

// File: tb/tb_hps_matrix_loader.sv
// Scoreboarded bench for hps_matrix_loader: stimulus pushes expected operand
// pairs, a done-triggered monitor pops and compares them.
module tb_hps_matrix_loader;
  localparam int unsigned MW = 200;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mat_size = 2'b00;
  logic [MW-1:0] m1, m2;
  logic          busy, done, loaded;

  hps_matrix_loader_if hps ();

  hps_matrix_loader dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .mat_size    (mat_size),
    .hps         (hps.slave),
    .matrix1_out (m1),
    .matrix2_out (m2),
    .busy        (busy),
    .done        (done),
    .loaded      (loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MW-1:0] m1;
    logic [MW-1:0] m2;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   ack_rises = 0;
  logic ack_prev = 1'b0;

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: element k of a matrix is byte (k mod 4) of word k/4 of that matrix.
  function automatic exp_t model(input int sz, input logic [31:0] w[$]);
    exp_t r;
    int   n, e, wpm;
    n   = sz + 2;
    e   = n * n;
    wpm = (e + 3) / 4;
    r.m1 = '0;
    r.m2 = '0;
    for (int k = 0; k < e; k++) begin
      r.m1[MW-1-8*k -: 8] = 8'(w[k/4] >> (8 * (3 - k % 4)));
      r.m2[MW-1-8*k -: 8] = 8'(w[wpm + k/4] >> (8 * (3 - k % 4)));
    end
    return r;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest outstanding load.
  always @(negedge clk) begin
    if (hps.hps_ack && !ack_prev) ack_rises++;
    ack_prev = hps.hps_ack;
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("matrix1", m1, e.m1);
        check("matrix2", m2, e.m2);
        check("loaded_at_done", loaded, 1'b1);
        check("busy_at_done", busy, 1'b0);
      end
    end
  end

  task automatic pulse_start(input int sz);
    @(posedge clk); #1;
    start = 1'b1;
    mat_size = 2'(sz);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input int hold);
    int t;
    @(posedge clk); #1;
    hps.hps_req  = 1'b1;
    hps.hps_data = d;
    t = 0;
    do begin @(negedge clk); t++; end while (!hps.hps_ack && t < 20);
    check("ack_rise_latency", 32'(t), 32'd2);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("ack_held", hps.hps_ack, 1'b1);
    end
    @(posedge clk); #1;
    hps.hps_req  = 1'b0;
    hps.hps_data = 32'($urandom);
    t = 0;
    do begin @(negedge clk); t++; end while (hps.hps_ack && t < 20);
    check("ack_fall_latency", 32'(t), 32'd2);
  endtask

  // hold < 0 selects a random hold per word; inject issues a start after word 0.
  task automatic run_load(input int sz, input logic [31:0] w[$], input int hold, input bit inject);
    pulse_start(sz);
    exp_q.push_back(model(sz, w));
    check("busy_after_start", busy, 1'b1);
    check("loaded_cleared", loaded, 1'b0);
    check("m1_cleared", m1, '0);
    for (int i = 0; i < w.size(); i++) begin
      send_word(w[i], hold < 0 ? int'($urandom_range(0, 3)) : hold);
      if (inject && i == 0) begin
        pulse_start(0);
        check("busy_ignores_start", busy, 1'b1);
      end
      if (i != w.size() - 1) check("no_early_done", done, 1'b0);
    end
    @(negedge clk);
    check("done_latency", done, 1'b1);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("busy_after_done", busy, 1'b0);
    check("loaded_level", loaded, 1'b1);
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  function automatic int words_for(input int sz);
    return 2 * (((sz + 2) * (sz + 2) + 3) / 4);
  endfunction

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] w[$];
    logic [MW-1:0] v;
    hps.hps_req  = 1'b0;
    hps.hps_data = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_m1", m1, '0);
    check("rst_m2", m2, '0);
    check("rst_ack", hps.hps_ack, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_loaded", loaded, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Request in IDLE is not acknowledged and captures nothing.
    hps.hps_req  = 1'b1;
    hps.hps_data = 32'hDEADBEEF;
    repeat (4) begin
      @(negedge clk);
      check("idle_req_no_ack", hps.hps_ack, 1'b0);
    end
    check("idle_req_no_capture", m1, '0);
    hps.hps_req = 1'b0;

    // 2x2 directed.
    w = '{32'h01020304, 32'h05060708};
    run_load(0, w, 0, 1'b0);
    v = m1; check("2x2_m1_top", 200'(v[199:168]), 200'h01020304);
    v = m2; check("2x2_m2_top", 200'(v[199:168]), 200'h05060708);

    // 3x3 with a partial last word, each req held 10 cycles.
    w = '{32'h01020304, 32'h05060708, 32'h09AABBCC, 32'h11121314, 32'h15161718, 32'h19202122};
    run_load(1, w, 9, 1'b0);
    v = m1; check("3x3_m1_top", 200'(v[199:128]), 200'h010203040506070809);
    v = m1; check("3x3_m1_rest", 200'(v[127:0]), 200'h0);

    // 5x5 with element k = k+1 in both operands.
    w.delete();
    for (int m = 0; m < 2; m++)
      for (int l = 0; l < 7; l++)
        w.push_back({8'(4*l+1), 8'(4*l+2), 8'(4*l+3), 8'(4*l+4)});
    ack_rises = 0;
    run_load(3, w, -1, 1'b0);
    check("5x5_ack_count", 200'(ack_rises), 200'd14);
    v = m1; check("5x5_last_elem", 200'(v[7:0]), 200'h19);

    // 4x4 with a start pulse during the load.
    w.delete();
    for (int i = 0; i < 8; i++) w.push_back($urandom);
    run_load(2, w, -1, 1'b1);

    // Reset part-way through a 5x5 load.
    pulse_start(3);
    for (int i = 0; i < 3; i++) send_word($urandom, 0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("abort_m1", m1, '0);
    check("abort_m2", m2, '0);
    check("abort_ack", hps.hps_ack, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_loaded", loaded, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", done, 1'b0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("post_abort_idle", busy, 1'b0);
    end

    w = '{32'hA1B2C3D4, 32'hE5F60718};
    run_load(0, w, 1, 1'b0);

    // Randomised loads of every size.
    for (int r = 0; r < 12; r++) begin
      int sz;
      sz = int'($urandom_range(0, 3));
      w.delete();
      for (int i = 0; i < words_for(sz); i++) w.push_back($urandom);
      run_load(sz, w, -1, ($urandom_range(0, 3) == 0));
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 200'(exp_q.size()), 200'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
